// File: rtl/dlx_wb_fwd_if.sv
// Bundle between the DLX ID stage, the write-back controller and the register file ports.
// master drives the ID/datapath side; slave is the controller.
interface dlx_wb_fwd_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int RA = $clog2(NREG);

  logic            id_valid;
  logic [RA-1:0]   id_rs1;
  logic [RA-1:0]   id_rs2;
  logic            id_use1;
  logic            id_use2;
  logic [RA-1:0]   id_rd;
  logic            id_wr;
  logic            id_load;
  logic            flush;
  logic [XLEN-1:0] ex_result;
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] rf_s1;
  logic [XLEN-1:0] rf_s2;
  logic            stall;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            WB;
  logic [RA-1:0]   Rd;
  logic [XLEN-1:0] reg_s;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr, id_load, flush,
    output ex_result, mem_rdata, rf_s1, rf_s2,
    input  stall, op_a, op_b, WB, Rd, reg_s
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr, id_load, flush,
    input  ex_result, mem_rdata, rf_s1, rf_s2,
    output stall, op_a, op_b, WB, Rd, reg_s
  );
endinterface

// File: rtl/dlx_wb_fwd.sv
// DLX register-file write-side controller: tracks EX/MEM/WB destinations, drives the
// regfile write port from WB and resolves ID operands by bypass or stall.
module dlx_wb_fwd #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  dlx_wb_fwd_if.slave    bus
);
  localparam int RA = $clog2(NREG);

  logic            ex_valid, ex_wr, ex_load;
  logic [RA-1:0]   ex_rd;
  logic            mem_valid, mem_wr, mem_load;
  logic [RA-1:0]   mem_rd;
  logic [XLEN-1:0] mem_val;
  logic            wb_valid, wb_wr;
  logic [RA-1:0]   wb_rd;
  logic [XLEN-1:0] wb_val;

  logic            hx1, hm1, hw1, hx2, hm2, hw2;
  logic            stall_c;
  logic [XLEN-1:0] mem_fwd;

  function automatic logic hit(input logic v, input logic w, input logic [RA-1:0] rd,
                               input logic [RA-1:0] src, input logic use_src);
    return v && w && (rd == src) && (src != '0) && use_src;
  endfunction

  function automatic logic [XLEN-1:0] pick(input logic is_r0, input logic h_ex,
                                           input logic h_mem, input logic h_wb,
                                           input logic [XLEN-1:0] v_ex, input logic [XLEN-1:0] v_mem,
                                           input logic [XLEN-1:0] v_wb, input logic [XLEN-1:0] rf);
    if (is_r0)      return '0;
    else if (h_ex)  return v_ex;
    else if (h_mem) return v_mem;
    else if (h_wb)  return v_wb;
    else            return rf;
  endfunction

  always_comb begin
    hx1 = hit(ex_valid,  ex_wr,  ex_rd,  bus.id_rs1, bus.id_use1);
    hm1 = hit(mem_valid, mem_wr, mem_rd, bus.id_rs1, bus.id_use1);
    hw1 = hit(wb_valid,  wb_wr,  wb_rd,  bus.id_rs1, bus.id_use1);
    hx2 = hit(ex_valid,  ex_wr,  ex_rd,  bus.id_rs2, bus.id_use2);
    hm2 = hit(mem_valid, mem_wr, mem_rd, bus.id_rs2, bus.id_use2);
    hw2 = hit(wb_valid,  wb_wr,  wb_rd,  bus.id_rs2, bus.id_use2);
    mem_fwd = mem_load ? bus.mem_rdata : mem_val;
  end

  generate
    if (FWD_EN) begin : g_fwd
      // A load in EX has no data yet, so it cannot be the bypass source; stall covers it.
      assign stall_c  = bus.id_valid && !bus.flush && (hx1 || hx2) && ex_load;
      assign bus.op_a = pick(bus.id_rs1 == '0, hx1 && !ex_load, hm1, hw1,
                             bus.ex_result, mem_fwd, wb_val, bus.rf_s1);
      assign bus.op_b = pick(bus.id_rs2 == '0, hx2 && !ex_load, hm2, hw2,
                             bus.ex_result, mem_fwd, wb_val, bus.rf_s2);
    end else begin : g_nofwd
      assign stall_c  = bus.id_valid && !bus.flush && (hx1 || hm1 || hw1 || hx2 || hm2 || hw2);
      assign bus.op_a = bus.rf_s1;
      assign bus.op_b = bus.rf_s2;
    end
  endgenerate

  assign bus.stall = stall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_load   <= 1'b0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_load  <= 1'b0;
      mem_rd    <= '0;
      mem_val   <= '0;
      wb_valid  <= 1'b0;
      wb_wr     <= 1'b0;
      wb_rd     <= '0;
      wb_val    <= '0;
    end else begin
      ex_valid  <= bus.id_valid && !stall_c && !bus.flush;
      ex_wr     <= bus.id_wr;
      ex_load   <= bus.id_load;
      ex_rd     <= bus.id_rd;
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_load  <= ex_load;
      mem_rd    <= ex_rd;
      mem_val   <= bus.ex_result;
      wb_valid  <= mem_valid;
      wb_wr     <= mem_wr;
      wb_rd     <= mem_rd;
      wb_val    <= mem_fwd;
    end
  end

  // r0 is never written, even if an instruction names it as destination.
  assign bus.WB    = wb_valid && wb_wr && (wb_rd != '0);
  assign bus.Rd    = wb_rd;
  assign bus.reg_s = wb_val;
endmodule

// File: tb/tb_dlx_wb_fwd.sv
// Directed bench for dlx_wb_fwd: a forwarding instance and a no-forwarding instance,
// write-port results checked by a queue-based monitor, operand/stall values checked inline.
module tb_dlx_wb_fwd;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];

  dlx_wb_fwd_if #(.XLEN(32), .NREG(32)) ifa ();
  dlx_wb_fwd_if #(.XLEN(32), .NREG(32)) ifb ();

  dlx_wb_fwd #(.XLEN(32), .NREG(32), .FWD_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  dlx_wb_fwd #(.XLEN(32), .NREG(32), .FWD_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write-port pulse must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (ifa.WB) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_a_unexpected actual rd=%0d val=%0d required no write", ifa.Rd, ifa.reg_s);
        end else begin
          e = qa.pop_front();
          chk("wr_a_rd", 32'(ifa.Rd), 32'(e.rd));
          chk("wr_a_val", ifa.reg_s, e.val);
        end
      end
      if (ifb.WB) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_b_unexpected actual rd=%0d val=%0d required no write", ifb.Rd, ifb.reg_s);
        end else begin
          e = qb.pop_front();
          chk("wr_b_rd", 32'(ifb.Rd), 32'(e.rd));
          chk("wr_b_val", ifb.reg_s, e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drv_a(input bit v, input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                       input bit u2, input logic [4:0] rd, input bit w, input bit l, input bit f);
    ifa.id_valid = v; ifa.id_rs1 = rs1; ifa.id_rs2 = rs2; ifa.id_use1 = u1; ifa.id_use2 = u2;
    ifa.id_rd = rd; ifa.id_wr = w; ifa.id_load = l; ifa.flush = f;
  endtask

  task automatic drv_b(input bit v, input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                       input bit u2, input logic [4:0] rd, input bit w, input bit l, input bit f);
    ifb.id_valid = v; ifb.id_rs1 = rs1; ifb.id_rs2 = rs2; ifb.id_use1 = u1; ifb.id_use2 = u2;
    ifb.id_rd = rd; ifb.id_wr = w; ifb.id_load = l; ifb.flush = f;
  endtask

  task automatic exp_a(input logic [4:0] rd, input logic [31:0] val);
    qa.push_back(wr_t'{rd: rd, val: val});
  endtask

  task automatic exp_b(input logic [4:0] rd, input logic [31:0] val);
    qb.push_back(wr_t'{rd: rd, val: val});
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ifa.ex_result = '0; ifa.mem_rdata = '0; ifa.rf_s1 = '0; ifa.rf_s2 = '0;
    ifb.ex_result = '0; ifb.mem_rdata = '0; ifb.rf_s1 = '0; ifb.rf_s2 = '0;
    #2;
    chk("rst_wb", 32'(ifa.WB), 32'd0);
    chk("rst_rd", 32'(ifa.Rd), 32'd0);
    chk("rst_reg_s", ifa.reg_s, 32'd0);
    chk("rst_stall", 32'(ifa.stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset with r1 in WB and r2 in MEM: immediate clear, r2 never written.
    drv_a(1, 0, 0, 0, 0, 5'd1, 1, 0, 0); exp_a(5'd1, 32'd1); step();
    ifa.ex_result = 32'd1; drv_a(1, 0, 0, 0, 0, 5'd2, 1, 0, 0); step();
    ifa.ex_result = 32'd2; drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    settle();
    chk("t1_wb_before_rst", 32'(ifa.WB), 32'd1);
    #4 rst_n = 1'b0;
    #1;
    chk("t1_rst_wb", 32'(ifa.WB), 32'd0);
    chk("t1_rst_rd", 32'(ifa.Rd), 32'd0);
    chk("t1_rst_reg_s", ifa.reg_s, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) step();

    // EX, MEM and WB bypass of r7.
    drv_a(1, 0, 0, 0, 0, 5'd7, 1, 0, 0); exp_a(5'd7, 32'd111111); step();
    ifa.ex_result = 32'd111111; ifa.rf_s1 = 32'hdeadbeef; ifa.rf_s2 = 32'hdeadbeef;
    drv_a(1, 5'd7, 0, 1, 0, 0, 0, 0, 0); settle();
    chk("t2_op_a_ex", ifa.op_a, 32'd111111);
    chk("t2_stall", 32'(ifa.stall), 32'd0);
    step();
    drv_a(1, 0, 5'd7, 0, 1, 0, 0, 0, 0); settle();
    chk("t2_op_b_mem", ifa.op_b, 32'd111111);
    chk("t2_wb_not_yet", 32'(ifa.WB), 32'd0);
    step();
    drv_a(1, 5'd7, 0, 1, 0, 0, 0, 0, 0); settle();
    chk("t2_op_a_wb", ifa.op_a, 32'd111111);
    chk("t2_wb_timing", 32'(ifa.WB), 32'd1);
    step();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Load-use: one bubble, then MEM bypass of the load data.
    drv_a(1, 0, 0, 0, 0, 5'd3, 1, 1, 0); exp_a(5'd3, 32'd222222); step();
    drv_a(1, 5'd3, 0, 1, 0, 0, 0, 0, 0); settle();
    chk("t3_stall_1", 32'(ifa.stall), 32'd1);
    step();
    ifa.mem_rdata = 32'd222222; settle();
    chk("t3_stall_2", 32'(ifa.stall), 32'd0);
    chk("t3_op_a_mem", ifa.op_a, 32'd222222);
    step();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("t3_wb_load", 32'(ifa.WB), 32'd1);
    step(); settle();
    chk("t3_wb_bubble", 32'(ifa.WB), 32'd0);
    step();

    // Load-use reader that is flushed never stalls.
    drv_a(1, 0, 0, 0, 0, 5'd4, 1, 1, 0); exp_a(5'd4, 32'd222222); step();
    drv_a(1, 0, 5'd4, 0, 1, 0, 0, 0, 1); settle();
    chk("t3_flush_stall", 32'(ifa.stall), 32'd0);
    step();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();

    // r0 destination is never written; r0 source reads as zero.
    drv_a(1, 0, 0, 0, 0, 5'd0, 1, 0, 0); step();
    ifa.ex_result = 32'd333333; ifa.rf_s2 = 32'hffffffff;
    drv_a(1, 0, 5'd0, 0, 1, 0, 0, 0, 0); settle();
    chk("t4_op_b_r0", ifa.op_b, 32'd0);
    chk("t4_stall", 32'(ifa.stall), 32'd0);
    step();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); settle();
    chk("t4_wb_r0", 32'(ifa.WB), 32'd0);
    step();

    // Back-to-back writers of r7: the younger (EX) wins.
    drv_a(1, 0, 0, 0, 0, 5'd7, 1, 0, 0); exp_a(5'd7, 32'd444444); step();
    ifa.ex_result = 32'd444444; drv_a(1, 0, 0, 0, 0, 5'd7, 1, 0, 0); exp_a(5'd7, 32'd555555); step();
    ifa.ex_result = 32'd555555; ifa.rf_s1 = 32'hdeadbeef;
    drv_a(1, 5'd7, 0, 1, 0, 0, 0, 0, 0); settle();
    chk("t5_op_a_youngest", ifa.op_a, 32'd555555);
    step();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (4) step();

    // No-forwarding instance: a RAW reader waits until the writer has left WB.
    drv_b(1, 0, 0, 0, 0, 5'd10, 1, 0, 0); exp_b(5'd10, 32'd1); step();
    ifb.ex_result = 32'd1; ifb.rf_s1 = 32'h55;
    drv_b(1, 5'd10, 0, 1, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (!ifb.stall) break;
      n++;
      step();
    end
    chk("t6_stall_cycles", 32'(n), 32'd3);
    chk("t6_op_a_rf", ifb.op_a, 32'h55);
    step();
    drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    // Flushed RAW reader: no stall and it never enters EX.
    drv_b(1, 0, 0, 0, 0, 5'd10, 1, 0, 0); exp_b(5'd10, 32'd1); step();
    drv_b(1, 5'd10, 0, 1, 0, 5'd11, 1, 0, 1); settle();
    chk("t6_flush_stall", 32'(ifb.stall), 32'd0);
    step();
    drv_b(1, 5'd11, 0, 1, 0, 0, 0, 0, 0); settle();
    chk("t6_flush_no_ex", 32'(ifb.stall), 32'd0);
    step();
    drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (5) step();

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
